mul_seq_32: RTL and testbench
=============================

// Module: mul_seq_32
// PURPOSE
// - Iterative 32x32 unsigned shift-add multiplier. Time-shares one 32-bit ripple adder
//   (adder_32, c=0, control=0) over 32 cycles and produces a 64-bit product.
// - Sits beside the ALU datapath. A start/busy/done handshake lets the control unit
//   issue a multiply and wait for done.
// PARAMETERS
// - WIDTH  32  operand width; must equal 32 (adder width), elaboration $error otherwise
// PORTS
// - clk      in   1   single clock, rising edge
// - rst_n    in   1   asynchronous active-low reset
// - start    in   1   request; sampled only in IDLE or DONE
// - a        in   32  multiplicand, captured on accepted start
// - b        in   32  multiplier, captured on accepted start
// - busy     out  1   high while state==CALC
// - done     out  1   high exactly one cycle, in state DONE
// - product  out  64  {hi,lo}; final value valid from done until next accepted start
// - hi_nz    out  1   product[63:32]!=0 (result does not fit in 32 bits); valid with product
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, cnt=0, mcand=0, hi=0, lo=0, so busy=0, done=0,
//   product=0, hi_nz=0. Reset mid-CALC aborts the operation; no done is produced.
// - Regs: mcand[31:0], hi[31:0], lo[31:0] (lo starts as the multiplier), cnt[4:0].
// - FSM states: IDLE, CALC, DONE.
//   - IDLE: start=1 -> load mcand=a, hi=0, lo=b, cnt=0 -> CALC. Otherwise stay.
//   - CALC: one iteration per edge.
//     - Adder inputs are hi and (lo[0] ? mcand : 0). Outputs are s[31:0] and carry co.
//     - Update {hi,lo} <= {co, s, lo[31:1]}. This is a 65-bit value shifted right by 1.
//     - cnt <= cnt+1. When cnt==31 on this edge -> DONE (32 iterations in total).
//     - start is ignored in CALC, including inputs a and b.
//   - DONE: done=1 for this cycle.
//     - start=1 -> reload as in IDLE -> CALC (back-to-back, no idle bubble).
//     - Else -> IDLE. product and hi_nz are held.
// - Latency: start sampled at edge k -> busy high for cycles after edges k..k+31.
//   - The DONE state is entered at edge k+32, so done is high in the cycle after
//     edge k+32 (33 edges from start).
// - product is the registered {hi,lo}. Its intermediate values during CALC are
//   don't-care; consumers use it only when done=1 or later.
// - Adder overflow output is unused. The carry into bit 63 never exceeds 64-bit range,
//   because hi+mcand < 2^33 and the 65-bit shift drops nothing.
// - Simultaneous start with rst_n=0: reset wins.
// - start held high continuously: a new operation begins every 33 edges
//   (from DONE straight to CALC).
// - cnt wraps 31->0 on the DONE transition. No other use of wrap.
// TESTING
// - Reset: rst_n=0 with start=1 -> busy=0, done=0, product=0. After release and
//   start=0 for 5 cycles -> stays IDLE.
// - 3 x 5: start at edge k -> busy for 32 cycles; done at cycle k+32;
//   product=64'h0000_0000_0000_000F, hi_nz=0.
// - FFFFFFFF x FFFFFFFF -> product=64'hFFFF_FFFE_0000_0001, hi_nz=1.
//   0 x 12345678 -> product=0.
// - start pulsed during CALC with new a and b -> ignored; result is that of the
//   original operands; done pulses only once.
// - rst_n pulsed low at iteration 10 -> all outputs 0 immediately (async), no done.
//   A new 7 x 6 then yields 42 after 33 edges.
// - start held high across DONE: 2 x 2 then 10000 x 10000 (hex) -> done pulses
//   33 edges apart, products 4 and 64'h0000_0001_0000_0000.

Source files
------------

// File: rtl/mul_seq_32.sv
// Iterative 32x32 unsigned shift-add multiplier: one ripple add per cycle over 32 cycles,
// 64-bit product with a start/busy/done handshake.
module mul_seq_32 #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 hi_nz
);

    generate
        if (WIDTH != 32) begin : g_width_check
            $error("mul_seq_32: WIDTH must be 32");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [4:0]         cnt_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;
    logic               hi_nz_r;

    logic [WIDTH-1:0]   addend_s;
    logic [WIDTH:0]     sum_s;

    // Carry-in fixed at zero; the returned MSB is the carry out.
    function automatic logic [WIDTH:0] ripple_add(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        logic             c;
        logic [WIDTH-1:0] s;
        c = 1'b0;
        s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    // Adder operands for this iteration: partial high word plus gated multiplicand.
    always_comb begin
        addend_s = {WIDTH{1'b0}};
        if (lo_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = {WIDTH{1'b0}};
        end
        sum_s = ripple_add(hi_r, addend_s);
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 5'd0;
            mcand_r <= {WIDTH{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            hi_nz_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        mcand_r <= a;
                        hi_r    <= {WIDTH{1'b0}};
                        lo_r    <= b;
                        cnt_r   <= 5'd0;
                        hi_nz_r <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= CALC;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    // 65-bit {co, s, lo} shifted right by one.
                    hi_r  <= sum_s[WIDTH:1];
                    lo_r  <= {sum_s[0], lo_r[WIDTH-1:1]};
                    cnt_r <= cnt_r + 5'd1;
                    if (cnt_r == 5'd31) begin
                        hi_nz_r <= (sum_s[WIDTH:1] != {WIDTH{1'b0}});
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= CALC;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        mcand_r <= a;
                        hi_r    <= {WIDTH{1'b0}};
                        lo_r    <= b;
                        cnt_r   <= 5'd0;
                        hi_nz_r <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= CALC;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = {hi_r, lo_r};
    assign hi_nz   = hi_nz_r;

endmodule

// File: tb/tb_mul_seq_32.sv
// Scoreboard bench for mul_seq_32: driver pushes expected products and timing,
// a negedge monitor checks handshake and results.
module tb_mul_seq_32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic        hi_nz;

    typedef struct {
        logic [63:0] prod;
        int          k;     // edge at which start is sampled
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    mul_seq_32 #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .hi_nz   (hi_nz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: done must appear exactly 32 edges after the start edge, busy in between.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (q.size() == 0 || cyc < q[0].k) begin
                chk("busy_idle", {63'd0, busy}, 64'd0);
                chk("done_idle", {63'd0, done}, 64'd0);
            end else if (cyc <= q[0].k + 31) begin
                chk("busy_calc", {63'd0, busy}, 64'd1);
                chk("done_calc", {63'd0, done}, 64'd0);
            end else begin
                chk("done_pulse", {63'd0, done}, 64'd1);
                chk("busy_done", {63'd0, busy}, 64'd0);
                chk("product", product, q[0].prod);
                chk("hi_nz", {63'd0, hi_nz}, {63'd0, (q[0].prod >= 64'h1_0000_0000)});
                void'(q.pop_front());
            end
        end
    end

    task automatic issue(input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        @(negedge clk);
        start  = 1'b1;
        a      = x;
        b      = y;
        e.prod = 64'(x) * 64'(y);
        e.k    = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80 && q.size() != 0; i++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL done_timeout actual=pending(%0d) expected=none", q.size());
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        exp_t        e;
        int          k;
        logic [31:0] x;
        logic [31:0] y;

        // Reset asserted together with start: reset wins.
        rst_n = 1'b0;
        start = 1'b1;
        a     = 32'd3;
        b     = 32'd5;
        #12;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_product", product, 64'd0);
        chk("rst_hi_nz", {63'd0, hi_nz}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_product", product, 64'd0);

        issue(32'd3, 32'd5);
        wait_idle();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle();
        issue(32'd0, 32'h1234_5678);
        wait_idle();

        // start pulsed mid-calculation with other operands is ignored.
        issue(32'd1000, 32'd77);
        repeat (5) @(negedge clk);
        start = 1'b1;
        a     = 32'hAAAA_5555;
        b     = 32'h0F0F_0F0F;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);

        // Asynchronous reset during iteration 10 aborts the operation.
        issue(32'hDEAD_BEEF, 32'h1234_5678);
        repeat (9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_product", product, 64'd0);
        chk("abort_hi_nz", {63'd0, hi_nz}, 64'd0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        issue(32'd7, 32'd6);
        wait_idle();

        // start held high: DONE goes straight back to CALC.
        @(negedge clk);
        start  = 1'b1;
        a      = 32'd2;
        b      = 32'd2;
        k      = cyc + 1;
        e.prod = 64'd4;
        e.k    = k;
        q.push_back(e);
        repeat (33) @(negedge clk);
        a      = 32'h0001_0000;
        b      = 32'h0001_0000;
        e.prod = 64'h0000_0001_0000_0000;
        e.k    = k + 33;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Randomized operands across magnitude classes.
        for (int n = 0; n < 16; n++) begin
            case (n % 4)
                0: begin x = $urandom; y = $urandom; end
                1: begin x = $urandom_range(0, 255); y = $urandom; end
                2: begin x = $urandom; y = 32'h1 << $urandom_range(0, 31); end
                default: begin x = $urandom_range(0, 65535); y = $urandom_range(0, 65535); end
            endcase
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(x, y);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
